// File: rtl/hyp_pkg.sv
// rtl/hyp_pkg.sv - shared types and constants for the hypotenuse request arbiter
// Purpose: FSM state encoding, default operand/result widths and the fill value
//          returned in place of a result when the datapath times out.
// Ports:   none (package).
package hyp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int DW_DEF = 8;
    localparam int RW_DEF = 8;

    // Every result bit takes this value on timeout, giving an all-ones result.
    localparam logic TIMEOUT_FILL = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
// Purpose: picks the first requester strictly after last_grant (wrapping).
// Ports:   req        - request vector
//          last_grant - index of the most recently served requester
//          grant      - one-hot grant (all zero when no request)
//          grant_idx  - binary index of the granted requester
//          any        - at least one request is present
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            any
);

    logic [IW-1:0] idx;

    // Scan offsets 1..NREQ so last_grant itself is considered last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IW'((int'(last_grant) + i) % NREQ);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/hyp_req_arbiter.sv
// rtl/hyp_req_arbiter.sv - shares one sqrt(x*x+y*y) datapath among NREQ requesters
// Purpose: round-robin grant, start/done sequencing with timeout abort, and a
//          valid/ready response carrying requester id, result and error flag.
// Ports:   clk, rst                       - clock, synchronous active-high reset
//          req_valid/req_ready/req_x/req_y - packed requester interface
//          dp_start/dp_x/dp_y/dp_done/dp_result/dp_abort - datapath handshake
//          rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_err   - response port
//          busy, err_cnt                   - status
module hyp_req_arbiter
    import hyp_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = DW_DEF,
    parameter int RW      = RW_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*DW-1:0]      req_x,
    input  logic [NREQ*DW-1:0]      req_y,
    output logic                    dp_start,
    output logic [DW-1:0]           dp_x,
    output logic [DW-1:0]           dp_y,
    input  logic                    dp_done,
    input  logic [RW-1:0]           dp_result,
    output logic                    dp_abort,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [RW-1:0]           rsp_data,
    output logic                    rsp_err,
    output logic                    busy,
    output logic [7:0]              err_cnt
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] last_grant;
    logic [TW-1:0] timer;
    logic [NREQ-1:0] grant;
    logic [IW-1:0] grant_idx;
    logic          grant_any;
    logic          timed_out;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any        (grant_any)
    );

    // Done has priority over the timeout in the same cycle.
    assign timed_out = (timer == TW'(TIMEOUT - 1)) && !dp_done;

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        dp_start  = 1'b0;
        dp_abort  = 1'b0;
        case (state)
            ST_IDLE: begin
                // Gated by rst so no requester believes it was accepted into a
                // transaction that the reset is about to discard.
                if (grant_any && !rst) begin
                    req_ready = grant;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                dp_start  = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (dp_done) begin
                    state_nxt = ST_RESP;
                end else if (timed_out) begin
                    dp_abort  = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= IW'(NREQ - 1);
            timer      <= '0;
            dp_x       <= '0;
            dp_y       <= '0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        last_grant <= grant_idx;
                        rsp_id     <= grant_idx;
                        dp_x       <= req_x[grant_idx*DW +: DW];
                        dp_y       <= req_y[grant_idx*DW +: DW];
                    end
                end
                ST_ISSUE: timer <= '0;
                ST_WAIT: begin
                    timer <= timer + TW'(1);
                    if (dp_done) begin
                        rsp_data <= dp_result;
                        rsp_err  <= 1'b0;
                    end else if (timed_out) begin
                        rsp_data <= {RW{TIMEOUT_FILL}};
                        rsp_err  <= 1'b1;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hyp_req_arbiter.sv
// tb/tb_hyp_req_arbiter.sv - self-checking bench for hyp_req_arbiter
module tb_hyp_req_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 8;
    localparam int RW      = 8;
    localparam int TIMEOUT = 64;
    localparam int IW      = $clog2(NREQ);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*DW-1:0]   req_x;
    logic [NREQ*DW-1:0]   req_y;
    logic                 dp_start;
    logic [DW-1:0]        dp_x;
    logic [DW-1:0]        dp_y;
    logic                 dp_done;
    logic [RW-1:0]        dp_result;
    logic                 dp_abort;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IW-1:0]        rsp_id;
    logic [RW-1:0]        rsp_data;
    logic                 rsp_err;
    logic                 busy;
    logic [7:0]           err_cnt;

    always #5 clk = ~clk;

    hyp_req_arbiter #(
        .NREQ (NREQ), .DW (DW), .RW (RW), .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk), .rst (rst),
        .req_valid (req_valid), .req_ready (req_ready),
        .req_x (req_x), .req_y (req_y),
        .dp_start (dp_start), .dp_x (dp_x), .dp_y (dp_y),
        .dp_done (dp_done), .dp_result (dp_result), .dp_abort (dp_abort),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready),
        .rsp_id (rsp_id), .rsp_data (rsp_data), .rsp_err (rsp_err),
        .busy (busy), .err_cnt (err_cnt)
    );

    int checks = 0;
    int errors = 0;
    int sb[$];

    int ox[NREQ][8];
    int oy[NREQ][8];
    int head[NREQ];
    int tail[NREQ];

    int   cyc = 0;
    int   start_cyc = 0;
    int   abort_cyc = 0;
    logic prev_grant = 1'b0;

    logic [NREQ-1:0] n_req_ready;
    logic            n_rsp_valid;
    logic [IW-1:0]   n_rsp_id;
    logic [RW-1:0]   n_rsp_data;
    logic            n_rsp_err;
    logic            n_dp_start;
    logic            n_dp_abort;
    logic [DW-1:0]   n_dp_x;
    logic [DW-1:0]   n_dp_y;

    int   dp_lat = 5;
    logic dp_hang = 1'b0;
    logic m_active = 1'b0;
    int   m_cnt = 0;
    int   m_res = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic push_exp(input int id, input int data, input int err);
        sb.push_back(id * 1024 + err * 256 + data);
    endtask

    task automatic update_inputs();
        for (int i = 0; i < NREQ; i++) begin
            if (head[i] < tail[i]) begin
                req_valid[i]       = 1'b1;
                req_x[i*DW +: DW]  = DW'(ox[i][head[i]]);
                req_y[i*DW +: DW]  = DW'(oy[i][head[i]]);
            end else begin
                req_valid[i]       = 1'b0;
                req_x[i*DW +: DW]  = '0;
                req_y[i*DW +: DW]  = '0;
            end
        end
    endtask

    task automatic add_req(input int i, input int x, input int y);
        ox[i][tail[i]] = x;
        oy[i][tail[i]] = y;
        tail[i]++;
        update_inputs();
    endtask

    // One clock: sample at negedge, then after the edge retire handshakes,
    // advance requesters and step the datapath model.
    task automatic cycle();
        logic got;
        int   g_id, g_data, g_err, e;
        @(negedge clk);
        n_req_ready = req_ready;
        n_rsp_valid = rsp_valid;
        n_rsp_id    = rsp_id;
        n_rsp_data  = rsp_data;
        n_rsp_err   = rsp_err;
        n_dp_start  = dp_start;
        n_dp_abort  = dp_abort;
        n_dp_x      = dp_x;
        n_dp_y      = dp_y;
        got    = !rst && rsp_valid && rsp_ready;
        g_id   = int'(rsp_id);
        g_data = int'(rsp_data);
        g_err  = int'(rsp_err);
        if (!rst) check("dp_start_lat", dp_start, prev_grant);
        if (dp_start) start_cyc = cyc;
        if (dp_abort) abort_cyc = cyc;
        @(posedge clk);
        #1;
        cyc++;
        prev_grant = !rst && (n_req_ready != '0);
        if (got) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                check("rsp_id", g_id, e / 1024);
                check("rsp_err", g_err, (e / 256) % 4);
                check("rsp_data", g_data, e % 256);
            end
        end
        for (int i = 0; i < NREQ; i++) if (n_req_ready[i]) head[i]++;
        update_inputs();
        dp_done = 1'b0;
        if (m_active && !dp_hang) begin
            if (m_cnt == 1) begin
                dp_done   = 1'b1;
                dp_result = RW'(m_res);
                m_active  = 1'b0;
            end else begin
                m_cnt--;
            end
        end
        if (n_dp_start) begin
            m_active = 1'b1;
            m_cnt    = dp_lat;
            m_res    = isqrt(int'(n_dp_x) * int'(n_dp_x) + int'(n_dp_y) * int'(n_dp_y));
        end
        if (n_dp_abort) m_active = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        update_inputs();
        rsp_ready = 1'b1;
        dp_hang   = 1'b0;
        dp_lat    = 5;
        m_active  = 1'b0;
        dp_done   = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        prev_grant = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_dp_start"}, dp_start, 0);
        check({tag, "_dp_abort"}, dp_abort, 0);
        check({tag, "_dp_x"}, dp_x, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_id"}, rsp_id, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_rsp_err"}, rsp_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        if (sb.size() != 0) begin
            check({tag, "_budget"}, sb.size(), 0);
            sb.delete();
        end
        cycle();
        cycle();
    endtask

    initial begin
        int   n;
        logic [IW-1:0] h_id;
        logic [RW-1:0] h_data;

        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b1;
        dp_done   = 1'b0;
        dp_result = '0;

        do_reset();
        check_reset_outputs("reset");

        // Single request, latency 5
        push_exp(0, 5, 0);
        add_req(0, 3, 4);
        drain("single", 50);

        // All four at once from reset: order 0,1,2,3
        do_reset();
        push_exp(0, 25, 0);
        push_exp(1, 18, 0);
        push_exp(2, 5, 0);
        push_exp(3, 10, 0);
        add_req(0, 7, 24);
        add_req(1, 10, 15);
        add_req(2, 3, 4);
        add_req(3, 6, 8);
        drain("all4", 200);

        // Backpressure: response held while rsp_ready low
        do_reset();
        rsp_ready = 1'b0;
        push_exp(0, 10, 0);
        push_exp(1, 13, 0);
        add_req(0, 6, 8);
        add_req(1, 5, 12);
        n = 0;
        while (!n_rsp_valid && n < 50) begin
            cycle();
            n++;
        end
        check("bp_reach_resp", n_rsp_valid, 1);
        h_id   = n_rsp_id;
        h_data = n_rsp_data;
        for (int k = 0; k < 10; k++) begin
            cycle();
            check("bp_valid", n_rsp_valid, 1);
            check("bp_id", n_rsp_id, h_id);
            check("bp_data", n_rsp_data, h_data);
            check("bp_no_grant", n_req_ready, 0);
        end
        rsp_ready = 1'b1;
        drain("bp", 100);

        // Datapath hang -> timeout
        do_reset();
        dp_hang = 1'b1;
        push_exp(2, 255, 1);
        add_req(2, 1, 1);
        drain("timeout", 200);
        check("abort_time", abort_cyc - start_cyc, TIMEOUT);
        check("err_cnt_1", err_cnt, 1);
        dp_hang = 1'b0;

        // Reset during WAIT, late done must be ignored
        do_reset();
        add_req(0, 3, 4);
        n = 0;
        while (!n_dp_start && n < 20) begin
            cycle();
            n++;
        end
        check("rw_started", n_dp_start, 1);
        cycle();
        cycle();
        check("rw_busy_before", busy, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        prev_grant = 1'b0;
        check_reset_outputs("rst_wait");
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("rw_no_rsp", n_rsp_valid, 0);
            check("rw_idle", busy, 0);
        end

        // Fairness: req1 and req3 alternate
        do_reset();
        push_exp(1, 13, 0);
        push_exp(3, 15, 0);
        push_exp(1, 17, 0);
        push_exp(3, 29, 0);
        add_req(1, 5, 12);
        add_req(1, 8, 15);
        add_req(3, 9, 12);
        add_req(3, 20, 21);
        drain("fair", 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
